// File: rtl/numled_ctrl.sv
// rtl/numled_ctrl.sv - bus-programmable 8-digit multiplexed 7-segment display controller
module numled_ctrl #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [31:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  dp_q, dp_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  led_en_q, led_en_d;
  logic [6:0]  seg_q, seg_d;
  logic        led_dp_q, led_dp_d;
  logic [3:0]  nibble;
  logic [6:0]  seg_hi;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    dp_d   = dp_q;
    if (sel && we) begin
      case (reg_sel)
        2'd0:    data_d = wdata;
        2'd1:    mask_d = wdata[7:0];
        2'd2:    dp_d   = wdata[7:0];
        default: ;
      endcase
    end

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = 16'd0;
      idx_d     = idx_q + 3'd1;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
      idx_d     = idx_q;
    end

    // Display outputs come from the pre-edge register values, giving one cycle of latency.
    nibble = data_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
    seg_d    = ~seg_hi;
    led_en_d = 8'hFF;
    if (mask_q[idx_q]) led_en_d[idx_q] = 1'b0;
    led_dp_d = ~dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= 32'd0;
      mask_q    <= 8'hFF;
      dp_q      <= 8'h00;
      div_cnt_q <= 16'd0;
      idx_q     <= 3'd0;
      led_en_q  <= 8'hFF;
      seg_q     <= 7'h7F;
      led_dp_q  <= 1'b1;
    end else begin
      data_q    <= data_d;
      mask_q    <= mask_d;
      dp_q      <= dp_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      led_en_q  <= led_en_d;
      seg_q     <= seg_d;
      led_dp_q  <= led_dp_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (reg_sel)
        2'd0:    rdata = data_q;
        2'd1:    rdata = {24'd0, mask_q};
        2'd2:    rdata = {24'd0, dp_q};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign led_en = led_en_q;
  assign led_ca = seg_q[0];
  assign led_cb = seg_q[1];
  assign led_cc = seg_q[2];
  assign led_cd = seg_q[3];
  assign led_ce = seg_q[4];
  assign led_cf = seg_q[5];
  assign led_cg = seg_q[6];
  assign led_dp = led_dp_q;

endmodule

// File: tb/tb_numled_ctrl.sv
// tb/tb_numled_ctrl.sv - self-checking bench for numled_ctrl
module tb_numled_ctrl;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  reg_sel;
  logic [31:0] wdata, rdata;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic [6:0]  segs;

  int n_checks = 0;
  int n_errors = 0;

  numled_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .reg_sel(reg_sel),
    .wdata(wdata), .rdata(rdata), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  always #5 clk = ~clk;
  assign segs = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: digit index follows directly from the count of scan cycles since reset.
  logic [6:0]  seg_tbl [16];
  logic [31:0] m_data;
  logic [7:0]  m_mask, m_dp, e_en;
  logic [6:0]  e_seg;
  logic        e_dp;
  int          m_k = 0;
  bit          m_valid = 0;

  initial begin
    seg_tbl[0] = 7'h3F; seg_tbl[1] = 7'h06; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h4F;
    seg_tbl[4] = 7'h66; seg_tbl[5] = 7'h6D; seg_tbl[6] = 7'h7D; seg_tbl[7] = 7'h07;
    seg_tbl[8] = 7'h7F; seg_tbl[9] = 7'h6F; seg_tbl[10] = 7'h77; seg_tbl[11] = 7'h7C;
    seg_tbl[12] = 7'h39; seg_tbl[13] = 7'h5E; seg_tbl[14] = 7'h79; seg_tbl[15] = 7'h71;
  end

  always @(posedge clk) begin
    int i;
    if (rst) begin
      m_data = 32'd0; m_mask = 8'hFF; m_dp = 8'h00; m_k = 0;
      e_en = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      i = (m_k / SD) % 8;
      e_en = 8'hFF;
      if (m_mask[i]) e_en[i] = 1'b0;
      e_seg = ~seg_tbl[(m_data >> (4 * i)) & 32'hF];
      e_dp = ~m_dp[i];
      if (sel && we) begin
        if (reg_sel == 2'd0) m_data = wdata;
        else if (reg_sel == 2'd1) m_mask = wdata[7:0];
        else if (reg_sel == 2'd2) m_dp = wdata[7:0];
      end
      m_k++;
    end
    m_valid = 1;
  end

  function automatic logic [31:0] m_rdata();
    if (!sel) return 32'd0;
    case (reg_sel)
      2'd0: return m_data;
      2'd1: return {24'd0, m_mask};
      2'd2: return {24'd0, m_dp};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_led_en", {24'd0, led_en}, {24'd0, e_en});
      chk("model_segs", {25'd0, segs}, {25'd0, e_seg});
      chk("model_led_dp", {31'd0, led_dp}, {31'd0, e_dp});
      chk("model_rdata", rdata, m_rdata());
      chk("one_hot_en", {31'd0, $countones(~led_en) <= 1}, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input logic [7:0] v, input string nm);
    int n = 0;
    while (led_en !== v && n < 64) begin
      step();
      n++;
    end
    chk(nm, {24'd0, led_en}, {24'd0, v});
  endtask

  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; reg_sel = r; wdata = d;
    step();
    sel = 1'b0; we = 1'b0;
  endtask

  logic [7:0] walk [8];

  initial begin
    walk[0] = 8'hFD; walk[1] = 8'hFB; walk[2] = 8'hF7; walk[3] = 8'hEF;
    walk[4] = 8'hDF; walk[5] = 8'hBF; walk[6] = 8'h7F; walk[7] = 8'hFE;

    rst = 1'b1; sel = 1'b1; we = 1'b1; reg_sel = 2'd0; wdata = 32'hFFFFFFFF;
    repeat (3) step();
    chk("rst_led_en", {24'd0, led_en}, 32'h000000FF);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_segs", {25'd0, segs}, 32'h7F);
    rst = 1'b0; sel = 1'b0; we = 1'b0;
    step();
    chk("rel_led_en", {24'd0, led_en}, 32'h000000FE);
    chk("rel_segs", {25'd0, segs}, 32'h40);

    bus_wr(2'd0, 32'h76543210);
    bus_wr(2'd1, 32'h000000FF);
    wait_en(8'hFD, "scan_start");
    for (int j = 0; j < 8; j++) begin
      chk("scan_walk", {24'd0, led_en}, {24'd0, walk[j]});
      if (j == 4) chk("digit5_segs", {25'd0, segs}, 32'h12);
      repeat (SD) step();
    end

    bus_wr(2'd1, 32'h0000000F);
    bus_wr(2'd2, 32'h00000001);
    wait_en(8'hFD, "mask_sync");
    wait_en(8'hFE, "mask_d0");
    chk("dp_d0_on", {31'd0, led_dp}, 32'd0);
    repeat (SD) step();
    chk("mask_d1", {24'd0, led_en}, 32'h000000FD);
    chk("dp_d1_off", {31'd0, led_dp}, 32'd1);
    repeat (3 * SD) step();
    for (int c = 0; c < 4 * SD; c++) begin
      chk("mask_blank", {24'd0, led_en}, 32'h000000FF);
      step();
    end
    chk("mask_wrap", {24'd0, led_en}, 32'h000000FE);

    bus_wr(2'd3, 32'h12345678);
    sel = 1'b1; reg_sel = 2'd3; #1;
    chk("rd_reserved", rdata, 32'd0);
    sel = 1'b0; reg_sel = 2'd0; #1;
    chk("rd_nosel", rdata, 32'd0);
    sel = 1'b0; we = 1'b1; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; sel = 1'b1; reg_sel = 2'd0; #1;
    chk("wr_nosel_data", rdata, 32'h76543210);
    reg_sel = 2'd1; #1;
    chk("rd_mask", rdata, 32'h0000000F);
    reg_sel = 2'd2; #1;
    chk("rd_dp", rdata, 32'h00000001);
    sel = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    sel = 1'b1; we = 1'b1; reg_sel = 2'd0; wdata = 32'h0000000A;
    step();
    wdata = 32'h000000A0;
    step();
    sel = 1'b0; we = 1'b0;
    chk("sim_d1_old", {24'd0, led_en}, 32'h000000FD);
    chk("sim_segs_old", {25'd0, segs}, 32'h40);
    step();
    chk("sim_d1_new", {24'd0, led_en}, 32'h000000FD);
    chk("sim_segs_A", {25'd0, segs}, 32'h08);

    wait_en(8'hF7, "mid_d3");
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_en", {24'd0, led_en}, 32'h000000FF);
    rst = 1'b0;
    step();
    chk("post_rst_en", {24'd0, led_en}, 32'h000000FE);
    chk("post_rst_segs", {25'd0, segs}, 32'h40);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
